sdram_burst_arbiter: RTL and testbench
======================================

Name: sdram_burst_arbiter

Overview:
- Shares one SDRAM burst controller between two clients, e.g. the SD-card loader (ch0) and the VGA frame reader (ch1).
- Each client has an independent write-burst port and read-burst port, giving four requesters in total.
- A round-robin scheduler grants one whole burst at a time and drives the controller's wr_burst_*/rd_burst_* interface.
- It routes the data strobes and finish pulses back to the granted requester only.

Parameters:
- ADDR_W, 24, burst address width (bank+row+col).
- LEN_W, 9, burst length width.
- DQ_W, 16, data width.
- MIN_LEN, 4, smallest legal burst length; shorter requests are rejected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ch_wr_req  in  2  per-channel write request; level, held until that channel's ch_wr_finish.
- ch_wr_len  in  2*LEN_W  packed lengths, [LEN_W*i +: LEN_W] = channel i.
- ch_wr_addr  in  2*ADDR_W  packed write addresses.
- ch_wr_data  in  2*DQ_W  packed write data.
- ch_wr_data_req  out  2  data request, routed to the granted channel.
- ch_wr_finish  out  2  one-cycle write-done pulse.
- ch_rd_req  in  2  per-channel read request; level.
- ch_rd_len  in  2*LEN_W  packed read lengths.
- ch_rd_addr  in  2*ADDR_W  packed read addresses.
- ch_rd_data  out  DQ_W  read data, broadcast to both channels.
- ch_rd_data_valid  out  2  read valid, routed to the granted channel.
- ch_rd_finish  out  2  one-cycle read-done pulse.
- ch_len_err  out  2  one-cycle pulse on a rejected request.
- wr_burst_req  out  1  to controller.
- wr_burst_len  out  LEN_W  to controller.
- wr_burst_addr  out  ADDR_W  to controller.
- wr_burst_data  out  DQ_W  to controller.
- wr_burst_data_req  in  1  from controller.
- wr_burst_finish  in  1  from controller.
- rd_burst_req  out  1  to controller.
- rd_burst_len  out  LEN_W  to controller.
- rd_burst_addr  out  ADDR_W  to controller.
- rd_burst_data  in  DQ_W  from controller.
- rd_burst_data_valid  in  1  from controller.
- rd_burst_finish  in  1  from controller.
- busy  out  1  high whenever the state is not S_IDLE.

Behaviour:
- Requester index: 0 = ch0 wr, 1 = ch0 rd, 2 = ch1 wr, 3 = ch1 rd.
- Internal registers: 2-bit grant index gnt and 2-bit pointer last (last index served).
- Reset (rst high at a clk edge): state S_IDLE; last = 3, so ch0 wr has first priority; gnt = 0.
- Reset values: every output req/finish/err/valid/data_req = 0; len/addr/data outputs = 0; busy = 0.
- Reset mid-burst aborts arbitration immediately; the controller is reset by the same rst.
- States: S_IDLE, S_WR, S_RD, S_DONE.
- S_IDLE: scan indices last+1, last+2, … (mod 4); pick the first with its request high. If none, stay.
  - If the winner's len < MIN_LEN: pulse ch_len_err and the matching ch_*_finish next cycle; last <= winner; go to S_DONE; controller is not touched.
  - Otherwise: gnt <= winner; register winner's len/addr onto wr_burst_* or rd_burst_*; the matching *_burst_req <= 1 on the same edge; go to S_WR or S_RD.
- Latency: request high to controller req high is 1 cycle when idle.
- S_WR / S_RD:
  - Hold req, len and addr constant until the controller's finish pulse.
  - wr_burst_data = ch_wr_data slice of the granted channel (combinational mux on gnt).
  - ch_wr_data_req[c] = wr_burst_data_req only when gnt is the write index of channel c; 0 otherwise.
  - ch_rd_data_valid is routed the same way on gnt.
  - ch_rd_data = rd_burst_data, passed straight through.
- On the controller's finish pulse: deassert *_burst_req on that edge; ch_*_finish[c] <= 1 for one cycle; last <= gnt; go to S_DONE.
- S_DONE: one-cycle gap for the requester to drop its req; then go to S_IDLE. Requests are never evaluated in S_DONE.
- A finish pulse from the controller for the non-granted direction, or a finish in S_IDLE, is ignored.
- A request dropped mid-burst has no effect; the burst completes and finish is still pulsed.
- Requester len/addr/data may change freely while not granted.
- Simultaneous requests from all four requesters are each served once in 4 consecutive grants, in rotation order.

Test Plan:
- Reset, then ch0 wr (len 16, addr 0x000100) alone -> wr_burst_req=1 one cycle later with len 16, addr 0x000100. 16 data_req cycles appear on ch_wr_data_req[0] only. ch_wr_finish[0] pulses 1 cycle after wr_burst_finish. busy back to 0 two cycles later.
- All four requests held high from reset -> grant order ch0wr, ch0rd, ch1wr, ch1rd, then repeat. Controller *_burst_req is never high for two directions at once.
- ch1 rd len 640 while ch0 wr waiting -> 640 ch_rd_data_valid[1] pulses, zero on [0]. ch0 wr is granted 2 cycles after rd_burst_finish.
- ch0 rd len 3 -> ch_len_err[0] and ch_rd_finish[0] pulse together; rd_burst_req stays 0; next grant rotates to index 2.
- rst asserted during an S_RD burst -> next cycle all outputs 0, state S_IDLE; the first grant after release is ch0 wr.
- Spurious wr_burst_finish while in S_RD -> no state change, no ch_wr_finish pulse.

Source files
------------

// File: rtl/sdram_burst_arbiter_if.sv
// Bundle of client-side and controller-side burst signals around the
// SDRAM burst arbiter. The arbiter takes the master view; clients and
// controller together take the slave view.
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 9,
  parameter int DQ_W   = 16
);
  // Client write ports (index 0 = ch0, 1 = ch1 in every packed vector)
  logic [1:0]          ch_wr_req;
  logic [2*LEN_W-1:0]  ch_wr_len;
  logic [2*ADDR_W-1:0] ch_wr_addr;
  logic [2*DQ_W-1:0]   ch_wr_data;
  logic [1:0]          ch_wr_data_req;
  logic [1:0]          ch_wr_finish;
  // Client read ports
  logic [1:0]          ch_rd_req;
  logic [2*LEN_W-1:0]  ch_rd_len;
  logic [2*ADDR_W-1:0] ch_rd_addr;
  logic [DQ_W-1:0]     ch_rd_data;
  logic [1:0]          ch_rd_data_valid;
  logic [1:0]          ch_rd_finish;
  logic [1:0]          ch_len_err;
  // Controller write burst interface
  logic                wr_burst_req;
  logic [LEN_W-1:0]    wr_burst_len;
  logic [ADDR_W-1:0]   wr_burst_addr;
  logic [DQ_W-1:0]     wr_burst_data;
  logic                wr_burst_data_req;
  logic                wr_burst_finish;
  // Controller read burst interface
  logic                rd_burst_req;
  logic [LEN_W-1:0]    rd_burst_len;
  logic [ADDR_W-1:0]   rd_burst_addr;
  logic [DQ_W-1:0]     rd_burst_data;
  logic                rd_burst_data_valid;
  logic                rd_burst_finish;
  // Status
  logic                busy;

  modport master (
    input  ch_wr_req, ch_wr_len, ch_wr_addr, ch_wr_data,
    input  ch_rd_req, ch_rd_len, ch_rd_addr,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    output ch_wr_data_req, ch_wr_finish,
    output ch_rd_data, ch_rd_data_valid, ch_rd_finish, ch_len_err,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    output busy
  );

  modport slave (
    output ch_wr_req, ch_wr_len, ch_wr_addr, ch_wr_data,
    output ch_rd_req, ch_rd_len, ch_rd_addr,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    input  ch_wr_data_req, ch_wr_finish,
    input  ch_rd_data, ch_rd_data_valid, ch_rd_finish, ch_len_err,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    input  busy
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst controller between two
// clients, each with a write-burst and a read-burst port. Requester index:
// 0 = ch0 wr, 1 = ch0 rd, 2 = ch1 wr, 3 = ch1 rd (bit 1 = channel, bit 0 = read).
module sdram_burst_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 9,
  parameter int DQ_W    = 16,
  parameter int MIN_LEN = 4
) (
  input logic                   clk,
  input logic                   rst,
  sdram_burst_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        last_q, last_d;
  logic              wr_burst_req_q, wr_burst_req_d;
  logic [LEN_W-1:0]  wr_burst_len_q, wr_burst_len_d;
  logic [ADDR_W-1:0] wr_burst_addr_q, wr_burst_addr_d;
  logic              rd_burst_req_q, rd_burst_req_d;
  logic [LEN_W-1:0]  rd_burst_len_q, rd_burst_len_d;
  logic [ADDR_W-1:0] rd_burst_addr_q, rd_burst_addr_d;
  logic [1:0]        ch_wr_finish_q, ch_wr_finish_d;
  logic [1:0]        ch_rd_finish_q, ch_rd_finish_d;
  logic [1:0]        ch_len_err_q, ch_len_err_d;

  logic [3:0]        req_vec;
  logic              win_valid;
  logic [1:0]        win_idx;
  logic              win_ch, win_rd;
  logic [LEN_W-1:0]  wr_len_sel, rd_len_sel, win_len;
  logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel, win_addr;
  logic              gnt_ch;

  assign req_vec = {bus.ch_rd_req[1], bus.ch_wr_req[1],
                    bus.ch_rd_req[0], bus.ch_wr_req[0]};

  // Round-robin scan: first asserted request after the last one served
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      if (!win_valid && req_vec[last_q + 2'(i)]) begin
        win_valid = 1'b1;
        win_idx   = last_q + 2'(i);
      end
    end
  end

  assign win_ch      = win_idx[1];
  assign win_rd      = win_idx[0];
  assign wr_len_sel  = win_ch ? bus.ch_wr_len[LEN_W +: LEN_W]    : bus.ch_wr_len[0 +: LEN_W];
  assign rd_len_sel  = win_ch ? bus.ch_rd_len[LEN_W +: LEN_W]    : bus.ch_rd_len[0 +: LEN_W];
  assign wr_addr_sel = win_ch ? bus.ch_wr_addr[ADDR_W +: ADDR_W] : bus.ch_wr_addr[0 +: ADDR_W];
  assign rd_addr_sel = win_ch ? bus.ch_rd_addr[ADDR_W +: ADDR_W] : bus.ch_rd_addr[0 +: ADDR_W];
  assign win_len     = win_rd ? rd_len_sel  : wr_len_sel;
  assign win_addr    = win_rd ? rd_addr_sel : wr_addr_sel;
  assign gnt_ch      = gnt_q[1];

  // Next-state logic: grant, burst tracking and completion pulses
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    last_d          = last_q;
    wr_burst_req_d  = wr_burst_req_q;
    wr_burst_len_d  = wr_burst_len_q;
    wr_burst_addr_d = wr_burst_addr_q;
    rd_burst_req_d  = rd_burst_req_q;
    rd_burst_len_d  = rd_burst_len_q;
    rd_burst_addr_d = rd_burst_addr_q;
    ch_wr_finish_d  = 2'b00;
    ch_rd_finish_d  = 2'b00;
    ch_len_err_d    = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          if (win_len < LEN_W'(MIN_LEN)) begin
            // Too short: reject without touching the controller, but still
            // finish so the requester can drop its level request.
            ch_len_err_d[win_ch] = 1'b1;
            if (win_rd) ch_rd_finish_d[win_ch] = 1'b1;
            else        ch_wr_finish_d[win_ch] = 1'b1;
            last_d  = win_idx;
            state_d = S_DONE;
          end else begin
            gnt_d = win_idx;
            if (win_rd) begin
              rd_burst_req_d  = 1'b1;
              rd_burst_len_d  = win_len;
              rd_burst_addr_d = win_addr;
              state_d         = S_RD;
            end else begin
              wr_burst_req_d  = 1'b1;
              wr_burst_len_d  = win_len;
              wr_burst_addr_d = win_addr;
              state_d         = S_WR;
            end
          end
        end
      end
      S_WR: begin
        if (bus.wr_burst_finish) begin
          wr_burst_req_d         = 1'b0;
          ch_wr_finish_d[gnt_ch] = 1'b1;
          last_d                 = gnt_q;
          state_d                = S_DONE;
        end
      end
      S_RD: begin
        if (bus.rd_burst_finish) begin
          rd_burst_req_d         = 1'b0;
          ch_rd_finish_d[gnt_ch] = 1'b1;
          last_d                 = gnt_q;
          state_d                = S_DONE;
        end
      end
      default: state_d = S_IDLE;  // S_DONE: gap for the requester to drop req
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= S_IDLE;
      gnt_q           <= 2'd0;
      last_q          <= 2'd3;
      wr_burst_req_q  <= 1'b0;
      wr_burst_len_q  <= '0;
      wr_burst_addr_q <= '0;
      rd_burst_req_q  <= 1'b0;
      rd_burst_len_q  <= '0;
      rd_burst_addr_q <= '0;
      ch_wr_finish_q  <= 2'b00;
      ch_rd_finish_q  <= 2'b00;
      ch_len_err_q    <= 2'b00;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      last_q          <= last_d;
      wr_burst_req_q  <= wr_burst_req_d;
      wr_burst_len_q  <= wr_burst_len_d;
      wr_burst_addr_q <= wr_burst_addr_d;
      rd_burst_req_q  <= rd_burst_req_d;
      rd_burst_len_q  <= rd_burst_len_d;
      rd_burst_addr_q <= rd_burst_addr_d;
      ch_wr_finish_q  <= ch_wr_finish_d;
      ch_rd_finish_q  <= ch_rd_finish_d;
      ch_len_err_q    <= ch_len_err_d;
    end
  end

  // Data-path routing: strobes go only to the granted requester, and only mid-burst
  assign bus.wr_burst_data    = (state_q == S_WR)
                                ? (gnt_ch ? bus.ch_wr_data[DQ_W +: DQ_W] : bus.ch_wr_data[0 +: DQ_W])
                                : '0;
  assign bus.ch_wr_data_req   = {gnt_ch, !gnt_ch} & {2{(state_q == S_WR) && bus.wr_burst_data_req}};
  assign bus.ch_rd_data_valid = {gnt_ch, !gnt_ch} & {2{(state_q == S_RD) && bus.rd_burst_data_valid}};
  assign bus.ch_rd_data       = bus.rd_burst_data;

  assign bus.wr_burst_req  = wr_burst_req_q;
  assign bus.wr_burst_len  = wr_burst_len_q;
  assign bus.wr_burst_addr = wr_burst_addr_q;
  assign bus.rd_burst_req  = rd_burst_req_q;
  assign bus.rd_burst_len  = rd_burst_len_q;
  assign bus.rd_burst_addr = rd_burst_addr_q;
  assign bus.ch_wr_finish  = ch_wr_finish_q;
  assign bus.ch_rd_finish  = ch_rd_finish_q;
  assign bus.ch_len_err    = ch_len_err_q;
  assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed testbench for sdram_burst_arbiter. The burst length is widened
// to 10 bits so a full 640-pixel VGA line fits in one read burst.
module tb_sdram_burst_arbiter;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 10;
  localparam int DQ_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  sdram_burst_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DQ_W(DQ_W)) bus ();

  sdram_burst_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DQ_W(DQ_W), .MIN_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are stable 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ch_wr_req           = '0;
    bus.ch_wr_len           = '0;
    bus.ch_wr_addr          = '0;
    bus.ch_wr_data          = '0;
    bus.ch_rd_req           = '0;
    bus.ch_rd_len           = '0;
    bus.ch_rd_addr          = '0;
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_finish     = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.ch_wr_data          = 32'hBEEF_1234;
    bus.wr_burst_data_req   = 1'b1;
    bus.rd_burst_data_valid = 1'b1;
    apply_reset();
    #1;
    vectors++;
    if ({bus.wr_burst_req, bus.rd_burst_req, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_req_busy: got %b want 000", {bus.wr_burst_req, bus.rd_burst_req, bus.busy});
    end
    vectors++;
    if ({bus.wr_burst_len, bus.wr_burst_addr, bus.rd_burst_len, bus.rd_burst_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_len_addr: got wl=%0d wa=%h rl=%0d ra=%h want all 0",
               bus.wr_burst_len, bus.wr_burst_addr, bus.rd_burst_len, bus.rd_burst_addr);
    end
    vectors++;
    if (bus.wr_burst_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_wr_data: got %h want 0000", bus.wr_burst_data);
    end
    vectors++;
    if ({bus.ch_wr_data_req, bus.ch_rd_data_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 0000", {bus.ch_wr_data_req, bus.ch_rd_data_valid});
    end
    vectors++;
    if ({bus.ch_wr_finish, bus.ch_rd_finish, bus.ch_len_err} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b want 000000", {bus.ch_wr_finish, bus.ch_rd_finish, bus.ch_len_err});
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    int n0 = 0;
    int n1 = 0;
    int data_bad = 0;
    clear_inputs();
    apply_reset();
    bus.ch_wr_len[0 +: LEN_W]     = 10'd16;
    bus.ch_wr_addr[0 +: ADDR_W]   = 24'h000100;
    bus.ch_wr_data                = 32'h5A5A_A5A5;
    bus.ch_wr_req[0]              = 1'b1;
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.rd_burst_req, bus.wr_burst_len, bus.wr_burst_addr} !== {2'b10, 10'd16, 24'h000100}) begin
      miscompares++;
      $display("FAIL wr_grant: got req=%b%b len=%0d addr=%h want req=10 len=16 addr=000100",
               bus.wr_burst_req, bus.rd_burst_req, bus.wr_burst_len, bus.wr_burst_addr);
    end
    for (int i = 0; i < 16; i++) begin
      bus.wr_burst_data_req = 1'b1;
      #1;
      if (bus.ch_wr_data_req[0]) n0++;
      if (bus.ch_wr_data_req[1]) n1++;
      if (bus.wr_burst_data !== 16'hA5A5) data_bad++;
      tick();
    end
    bus.wr_burst_data_req = 1'b0;
    vectors++;
    if (n0 != 16 || n1 != 0) begin
      miscompares++;
      $display("FAIL wr_data_req_route: got ch0=%0d ch1=%0d want ch0=16 ch1=0", n0, n1);
    end
    vectors++;
    if (data_bad != 0) begin
      miscompares++;
      $display("FAIL wr_data_mux: got %0d bad beats want 0", data_bad);
    end
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    vectors++;
    if ({bus.ch_wr_finish, bus.wr_burst_req, bus.busy} !== 4'b0101) begin
      miscompares++;
      $display("FAIL wr_finish: got fin=%b req=%b busy=%b want fin=01 req=0 busy=1",
               bus.ch_wr_finish, bus.wr_burst_req, bus.busy);
    end
    bus.ch_wr_req[0] = 1'b0;
    tick();
    vectors++;
    if ({bus.ch_wr_finish, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL wr_back_idle: got fin=%b busy=%b want fin=00 busy=0", bus.ch_wr_finish, bus.busy);
    end
  endtask

  task automatic test_rotation();
    logic [1:0]        idx;
    logic [1:0]        chmask;
    logic [ADDR_W-1:0] got_addr;
    clear_inputs();
    bus.ch_wr_len  = {10'd8, 10'd8};
    bus.ch_rd_len  = {10'd8, 10'd8};
    bus.ch_wr_addr = {24'h000012, 24'h000010};
    bus.ch_rd_addr = {24'h000013, 24'h000011};
    bus.ch_wr_req  = 2'b11;
    bus.ch_rd_req  = 2'b11;
    apply_reset();
    tick();
    for (int k = 0; k < 5; k++) begin
      idx    = 2'(k % 4);
      chmask = idx[1] ? 2'b10 : 2'b01;
      vectors++;
      if ({bus.wr_burst_req, bus.rd_burst_req} !== (idx[0] ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL rot_dir_%0d: got wr=%b rd=%b want idx %0d", k, bus.wr_burst_req, bus.rd_burst_req, idx);
      end
      got_addr = idx[0] ? bus.rd_burst_addr : bus.wr_burst_addr;
      vectors++;
      if (got_addr !== 24'h000010 + 24'(idx)) begin
        miscompares++;
        $display("FAIL rot_addr_%0d: got %h want %h", k, got_addr, 24'h000010 + 24'(idx));
      end
      if (idx[0]) bus.rd_burst_finish = 1'b1;
      else        bus.wr_burst_finish = 1'b1;
      tick();
      bus.rd_burst_finish = 1'b0;
      bus.wr_burst_finish = 1'b0;
      vectors++;
      if ({bus.ch_rd_finish, bus.ch_wr_finish} !== (idx[0] ? {chmask, 2'b00} : {2'b00, chmask})) begin
        miscompares++;
        $display("FAIL rot_finish_%0d: got rd=%b wr=%b for idx %0d", k, bus.ch_rd_finish, bus.ch_wr_finish, idx);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_long_read();
    int v0 = 0;
    int v1 = 0;
    int data_bad = 0;
    int wr_seen = 0;
    clear_inputs();
    apply_reset();
    bus.ch_rd_len[LEN_W +: LEN_W]    = 10'd640;
    bus.ch_rd_addr[ADDR_W +: ADDR_W] = 24'h002000;
    bus.ch_rd_req[1]                 = 1'b1;
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.rd_burst_req, bus.rd_burst_len, bus.rd_burst_addr} !== {2'b01, 10'd640, 24'h002000}) begin
      miscompares++;
      $display("FAIL rd_grant: got req=%b%b len=%0d addr=%h want req=01 len=640 addr=002000",
               bus.wr_burst_req, bus.rd_burst_req, bus.rd_burst_len, bus.rd_burst_addr);
    end
    bus.ch_wr_len[0 +: LEN_W]   = 10'd16;
    bus.ch_wr_addr[0 +: ADDR_W] = 24'h000300;
    bus.ch_wr_req[0]            = 1'b1;
    for (int i = 0; i < 640; i++) begin
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = 16'(i * 3 + 1);
      #1;
      if (bus.ch_rd_data_valid[0]) v0++;
      if (bus.ch_rd_data_valid[1]) v1++;
      if (bus.ch_rd_data !== 16'(i * 3 + 1)) data_bad++;
      if (bus.wr_burst_req) wr_seen++;
      tick();
    end
    bus.rd_burst_data_valid = 1'b0;
    vectors++;
    if (v1 != 640 || v0 != 0) begin
      miscompares++;
      $display("FAIL rd_valid_route: got ch0=%0d ch1=%0d want ch0=0 ch1=640", v0, v1);
    end
    vectors++;
    if (data_bad != 0 || wr_seen != 0) begin
      miscompares++;
      $display("FAIL rd_data_excl: got bad=%0d wr_req_cycles=%0d want 0 0", data_bad, wr_seen);
    end
    bus.rd_burst_finish = 1'b1;
    tick();
    bus.rd_burst_finish = 1'b0;
    bus.ch_rd_req[1]    = 1'b0;
    vectors++;
    if (bus.ch_rd_finish !== 2'b10) begin
      miscompares++;
      $display("FAIL rd_finish: got %b want 10", bus.ch_rd_finish);
    end
    tick();
    vectors++;
    if (bus.wr_burst_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_gap: got %b want 0", bus.wr_burst_req);
    end
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.wr_burst_addr} !== {1'b1, 24'h000300}) begin
      miscompares++;
      $display("FAIL wr_after_rd: got req=%b addr=%h want req=1 addr=000300", bus.wr_burst_req, bus.wr_burst_addr);
    end
  endtask

  task automatic test_len_err();
    clear_inputs();
    apply_reset();
    bus.ch_rd_len[0 +: LEN_W] = 10'd3;
    bus.ch_rd_req[0]          = 1'b1;
    tick();
    vectors++;
    if ({bus.ch_len_err, bus.ch_rd_finish, bus.wr_burst_req, bus.rd_burst_req, bus.busy} !== 7'b0101001) begin
      miscompares++;
      $display("FAIL len_err: got err=%b fin=%b req=%b%b busy=%b want err=01 fin=01 req=00 busy=1",
               bus.ch_len_err, bus.ch_rd_finish, bus.wr_burst_req, bus.rd_burst_req, bus.busy);
    end
    bus.ch_rd_req[0] = 1'b0;
    bus.ch_wr_len    = {10'd8, 10'd4};
    bus.ch_wr_addr   = {24'h000500, 24'h000400};
    bus.ch_wr_req    = 2'b11;
    tick();
    vectors++;
    if ({bus.ch_len_err, bus.ch_rd_finish} !== 4'b0000) begin
      miscompares++;
      $display("FAIL len_err_pulse: got err=%b fin=%b want 00 00", bus.ch_len_err, bus.ch_rd_finish);
    end
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.wr_burst_addr} !== {1'b1, 24'h000500}) begin
      miscompares++;
      $display("FAIL len_err_rotate: got req=%b addr=%h want req=1 addr=000500", bus.wr_burst_req, bus.wr_burst_addr);
    end
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    bus.ch_wr_req[1]    = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.wr_burst_len, bus.wr_burst_addr, bus.ch_len_err} !== {1'b1, 10'd4, 24'h000400, 2'b00}) begin
      miscompares++;
      $display("FAIL min_len_ok: got req=%b len=%0d addr=%h err=%b want req=1 len=4 addr=000400 err=00",
               bus.wr_burst_req, bus.wr_burst_len, bus.wr_burst_addr, bus.ch_len_err);
    end
  endtask

  task automatic test_spurious_finish();
    clear_inputs();
    apply_reset();
    bus.rd_burst_finish = 1'b1;
    tick();
    bus.rd_burst_finish = 1'b0;
    vectors++;
    if ({bus.ch_rd_finish, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_finish: got fin=%b busy=%b want 00 0", bus.ch_rd_finish, bus.busy);
    end
    bus.ch_rd_len[0 +: LEN_W]   = 10'd8;
    bus.ch_rd_addr[0 +: ADDR_W] = 24'h000600;
    bus.ch_rd_req[0]            = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    vectors++;
    if ({bus.ch_wr_finish, bus.ch_rd_finish, bus.rd_burst_req, bus.busy} !== 6'b000011) begin
      miscompares++;
      $display("FAIL spurious_wr_finish: got wfin=%b rfin=%b rdreq=%b busy=%b want 00 00 1 1",
               bus.ch_wr_finish, bus.ch_rd_finish, bus.rd_burst_req, bus.busy);
    end
    bus.rd_burst_finish = 1'b1;
    tick();
    bus.rd_burst_finish = 1'b0;
    bus.ch_rd_req[0]    = 1'b0;
    vectors++;
    if (bus.ch_rd_finish !== 2'b01) begin
      miscompares++;
      $display("FAIL rd_finish_after_spurious: got %b want 01", bus.ch_rd_finish);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_inputs();
    apply_reset();
    bus.ch_rd_len[LEN_W +: LEN_W]    = 10'd32;
    bus.ch_rd_addr[ADDR_W +: ADDR_W] = 24'h000700;
    bus.ch_rd_req[1]                 = 1'b1;
    tick();
    bus.rd_burst_data_valid = 1'b1;
    tick();
    tick();
    rst                         = 1'b1;
    bus.ch_wr_len[0 +: LEN_W]   = 10'd16;
    bus.ch_wr_addr[0 +: ADDR_W] = 24'h000800;
    bus.ch_wr_req[0]            = 1'b1;
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.rd_burst_req, bus.busy, bus.ch_rd_data_valid, bus.ch_wr_data_req,
         bus.ch_wr_finish, bus.ch_rd_finish, bus.ch_len_err} !== 13'b0) begin
      miscompares++;
      $display("FAIL midrst_ctrl: got req=%b%b busy=%b valid=%b dreq=%b pulses=%b%b%b want all 0",
               bus.wr_burst_req, bus.rd_burst_req, bus.busy, bus.ch_rd_data_valid, bus.ch_wr_data_req,
               bus.ch_wr_finish, bus.ch_rd_finish, bus.ch_len_err);
    end
    vectors++;
    if ({bus.rd_burst_len, bus.rd_burst_addr} !== '0) begin
      miscompares++;
      $display("FAIL midrst_len_addr: got len=%0d addr=%h want 0 0", bus.rd_burst_len, bus.rd_burst_addr);
    end
    rst                     = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    tick();
    vectors++;
    if ({bus.wr_burst_req, bus.rd_burst_req, bus.wr_burst_addr} !== {2'b10, 24'h000800}) begin
      miscompares++;
      $display("FAIL midrst_first_grant: got req=%b%b addr=%h want req=10 addr=000800",
               bus.wr_burst_req, bus.rd_burst_req, bus.wr_burst_addr);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_rotation();
    test_long_read();
    test_len_err();
    test_spurious_finish();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
